// File: rtl/uriscv_lsu_mem_if.sv
// Single-outstanding data bus between the memory-access stage and the memory system.
// The master issues a request and holds it until accepted; the slave then answers with one ack.
interface uriscv_lsu_mem_if;
    logic        mem_rd;
    logic [3:0]  mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_wr;
    logic        mem_accept;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_data_rd;

    modport master (
        output mem_rd, mem_wr, mem_addr, mem_data_wr,
        input  mem_accept, mem_ack, mem_error, mem_data_rd
    );

    modport slave (
        input  mem_rd, mem_wr, mem_addr, mem_data_wr,
        output mem_accept, mem_ack, mem_error, mem_data_rd
    );
endinterface

// File: rtl/uriscv_lsu_mem.sv
// Memory-access stage: captures one LSU op, runs it over the data bus, then aligns and
// extends load data for writeback or reports a load/store/misaligned fault.
module uriscv_lsu_mem #(
    parameter bit          SUPPORT_TRAP_LSU_ALIGN = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES         = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    input  logic [31:0]             opcode_i,
    input  logic [4:0]              rd_idx_i,
    input  logic                    lsu_rd_i,
    input  logic [3:0]              lsu_wr_i,
    input  logic [31:0]             lsu_addr_i,
    input  logic [31:0]             lsu_data_i,
    input  logic                    lsu_misaligned_i,
    output logic                    req_ready_o,
    uriscv_lsu_mem_if.master        mem,
    output logic                    wb_valid_o,
    output logic [4:0]              wb_rd_o,
    output logic [31:0]             wb_value_o,
    output logic                    fault_load_o,
    output logic                    fault_store_o,
    output logic                    fault_misaligned_o,
    output logic [31:0]             fault_addr_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  func3_q;
    logic [4:0]  rd_q;
    logic        is_load_q;
    logic [31:0] cnt_q;

    logic        capture, trap, issue, done, timeout_hit, timeout;

    logic        mem_rd_d;
    logic [3:0]  mem_wr_d;
    logic [31:0] mem_addr_d, mem_data_wr_d;
    logic        wb_valid_d, fault_load_d, fault_store_d, fault_mis_d;
    logic [4:0]  wb_rd_d;
    logic [31:0] wb_value_d, fault_addr_d;

    // Only func3 of the instruction word matters here.
    logic unused_opcode;
    assign unused_opcode = ^{opcode_i[31:15], opcode_i[11:0]};

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*off +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return d;
        endcase
    endfunction

    assign capture     = (state_q == S_IDLE) && req_valid_i && (lsu_rd_i || (|lsu_wr_i));
    assign trap        = capture && lsu_misaligned_i && SUPPORT_TRAP_LSU_ALIGN;
    assign issue       = capture && !trap;
    assign done        = mem.mem_ack && ((state_q == S_REQ && mem.mem_accept) || state_q == S_RESP);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign timeout     = (state_q != S_IDLE) && !done && timeout_hit;
    assign req_ready_o = (state_q == S_IDLE);

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_REQ;
            S_REQ: begin
                if (done || timeout)     state_d = S_IDLE;
                else if (mem.mem_accept) state_d = S_RESP;
            end
            S_RESP:  if (done || timeout) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path infers a latch.
        mem_rd_d      = mem.mem_rd;
        mem_wr_d      = mem.mem_wr;
        mem_addr_d    = mem.mem_addr;
        mem_data_wr_d = mem.mem_data_wr;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_o;
        wb_value_d    = wb_value_o;
        fault_load_d  = 1'b0;
        fault_store_d = 1'b0;
        fault_mis_d   = 1'b0;
        fault_addr_d  = fault_addr_o;

        if (issue) begin
            mem_rd_d      = lsu_rd_i;
            mem_wr_d      = lsu_wr_i;
            mem_addr_d    = {lsu_addr_i[31:2], 2'b00};
            mem_data_wr_d = lsu_data_i;
        end

        // Strobes drop once the bus has taken the request or the watchdog gives up.
        if ((state_q == S_REQ && mem.mem_accept) || timeout) begin
            mem_rd_d = 1'b0;
            mem_wr_d = 4'b0;
        end

        if (done) begin
            if (mem.mem_error) begin
                fault_load_d  = is_load_q;
                fault_store_d = !is_load_q;
                fault_addr_d  = addr_q;
            end else if (is_load_q) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_value_d = extract(func3_q, addr_q[1:0], mem.mem_data_rd);
            end
        end

        if (timeout) begin
            fault_load_d  = is_load_q;
            fault_store_d = !is_load_q;
            fault_addr_d  = addr_q;
        end

        if (trap) begin
            fault_mis_d  = 1'b1;
            fault_addr_d = lsu_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q             <= '0;
            func3_q            <= '0;
            rd_q               <= '0;
            is_load_q          <= 1'b0;
            cnt_q              <= '0;
            mem.mem_rd         <= 1'b0;
            mem.mem_wr         <= '0;
            mem.mem_addr       <= '0;
            mem.mem_data_wr    <= '0;
            wb_valid_o         <= 1'b0;
            wb_rd_o            <= '0;
            wb_value_o         <= '0;
            fault_load_o       <= 1'b0;
            fault_store_o      <= 1'b0;
            fault_misaligned_o <= 1'b0;
            fault_addr_o       <= '0;
        end else begin
            if (capture) begin
                addr_q    <= lsu_addr_i;
                func3_q   <= opcode_i[14:12];
                rd_q      <= rd_idx_i;
                is_load_q <= lsu_rd_i;
                cnt_q     <= '0;
            end else if (state_q != S_IDLE) begin
                cnt_q <= cnt_q + 32'd1;
            end
            mem.mem_rd         <= mem_rd_d;
            mem.mem_wr         <= mem_wr_d;
            mem.mem_addr       <= mem_addr_d;
            mem.mem_data_wr    <= mem_data_wr_d;
            wb_valid_o         <= wb_valid_d;
            wb_rd_o            <= wb_rd_d;
            wb_value_o         <= wb_value_d;
            fault_load_o       <= fault_load_d;
            fault_store_o      <= fault_store_d;
            fault_misaligned_o <= fault_mis_d;
            fault_addr_o       <= fault_addr_d;
        end
    end

endmodule

// File: tb/tb_uriscv_lsu_mem.sv
// Bench for uriscv_lsu_mem: directed vector table, hand-written multi-cycle sequences and
// random ops checked against a transaction-level reference model.
module tb_uriscv_lsu_mem;

    localparam int TMO = 8;

    logic        clk, rst;
    logic        req_valid;
    logic [31:0] opcode;
    logic [4:0]  rd_idx;
    logic        lsu_rd;
    logic [3:0]  lsu_wr;
    logic [31:0] lsu_addr, lsu_data;
    logic        lsu_mis;

    logic        req_ready, wb_valid, f_ld, f_st, f_mis;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value, f_addr;

    logic        nt_ready, nt_wb_valid, nt_f_ld, nt_f_st, nt_f_mis;
    logic [4:0]  nt_wb_rd;
    logic [31:0] nt_wb_value, nt_f_addr;

    uriscv_lsu_mem_if bus ();
    uriscv_lsu_mem_if bus_nt ();

    // Second instance: no misalignment trap, no watchdog, bus always accepts and acks.
    assign bus_nt.mem_accept  = 1'b1;
    assign bus_nt.mem_ack     = 1'b1;
    assign bus_nt.mem_error   = 1'b0;
    assign bus_nt.mem_data_rd = 32'h0;

    uriscv_lsu_mem #(.SUPPORT_TRAP_LSU_ALIGN(1'b1), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .opcode_i(opcode), .rd_idx_i(rd_idx),
        .lsu_rd_i(lsu_rd), .lsu_wr_i(lsu_wr), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
        .lsu_misaligned_i(lsu_mis), .req_ready_o(req_ready), .mem(bus),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_value_o(wb_value),
        .fault_load_o(f_ld), .fault_store_o(f_st), .fault_misaligned_o(f_mis), .fault_addr_o(f_addr)
    );

    uriscv_lsu_mem #(.SUPPORT_TRAP_LSU_ALIGN(1'b0), .TIMEOUT_CYCLES(0)) dut_nt (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .opcode_i(opcode), .rd_idx_i(rd_idx),
        .lsu_rd_i(lsu_rd), .lsu_wr_i(lsu_wr), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
        .lsu_misaligned_i(lsu_mis), .req_ready_o(nt_ready), .mem(bus_nt),
        .wb_valid_o(nt_wb_valid), .wb_rd_o(nt_wb_rd), .wb_value_o(nt_wb_value),
        .fault_load_o(nt_f_ld), .fault_store_o(nt_f_st), .fault_misaligned_o(nt_f_mis),
        .fault_addr_o(nt_f_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        bit          ld;
        logic [3:0]  wr;
        logic [4:0]  rd;
        logic [31:0] addr, wdata, rdata;
        bit          mis, err;
        int          acc_dly, ack_dly;
        bit          e_wb;
        logic [31:0] e_val;
        bit          e_fl, e_fs;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cur_op = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL op%0d %s: got 0x%08h expected 0x%08h", cur_op, name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_valid = 1'b0;
        lsu_rd    = 1'b0;
        lsu_wr    = 4'b0;
        lsu_mis   = 1'b0;
    endtask

    task automatic present(input logic [2:0] f3, input bit ld, input logic [3:0] wr, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit mis);
        req_valid = 1'b1;
        opcode    = $urandom;
        opcode[14:12] = f3;
        rd_idx    = rd;
        lsu_rd    = ld;
        lsu_wr    = wr;
        lsu_addr  = addr;
        lsu_data  = wdata;
        lsu_mis   = mis;
    endtask

    // Reference load extraction from plain arithmetic on byte offsets.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned off, bv, hv;
        off = addr % 4;
        bv  = (rdata >> (8 * off)) % 256;
        hv  = (rdata >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0:    return (bv >= 128) ? bv - 256 : bv;
            3'd1:    return (hv >= 32768) ? hv - 65536 : hv;
            3'd4:    return bv;
            3'd5:    return hv;
            default: return rdata;
        endcase
    endfunction

    // Transaction outcome: misaligned traps, late ack (> TMO cycles) or error faults, loads write back.
    function automatic vec_t predict(input vec_t v);
        v.e_wb  = 1'b0;
        v.e_fl  = 1'b0;
        v.e_fs  = 1'b0;
        v.e_val = 32'h0;
        if (!v.mis) begin
            if ((v.acc_dly + 1 + v.ack_dly > TMO) || v.err) begin
                v.e_fl = v.ld;
                v.e_fs = !v.ld;
            end else if (v.ld) begin
                v.e_wb  = 1'b1;
                v.e_val = ref_load(v.f3, v.addr, v.rdata);
            end
        end
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        int          acc_c, ack_c, end_c;
        bit          to, on;
        logic [31:0] algn;
        algn = {v.addr[31:2], 2'b00};
        check("ready_before", req_ready, 1);
        present(v.f3, v.ld, v.wr, v.rd, v.addr, v.wdata, v.mis);
        tick();
        drive_idle();
        if (v.mis) begin
            check("mis_pulse", f_mis, 1);
            check("mis_addr", f_addr, v.addr);
            check("mis_no_rd", bus.mem_rd, 0);
            check("mis_no_wr", bus.mem_wr, 0);
            check("mis_ready", req_ready, 1);
            check("mis_wb", wb_valid, 0);
            check("noalign_rd", bus_nt.mem_rd, v.ld);
            check("noalign_addr", bus_nt.mem_addr, algn);
            tick();
            check("mis_pulse_end", f_mis, 0);
            return;
        end
        acc_c = v.acc_dly + 1;
        ack_c = acc_c + v.ack_dly;
        to    = (ack_c > TMO);
        end_c = to ? TMO : ack_c;
        for (int s = 1; s <= end_c; s++) begin
            on = (s <= acc_c);
            check("ready_busy", req_ready, 0);
            check("mem_rd", bus.mem_rd, on ? v.ld : 1'b0);
            check("mem_wr", bus.mem_wr, on ? v.wr : 4'd0);
            if (on) begin
                check("mem_addr", bus.mem_addr, algn);
                check("mem_data_wr", bus.mem_data_wr, v.wdata);
            end
            check("wb_busy", wb_valid, 0);
            bus.mem_accept  = (s == acc_c);
            bus.mem_ack     = (s == ack_c);
            bus.mem_error   = (s == ack_c) && v.err;
            bus.mem_data_rd = (s == ack_c) ? v.rdata : $urandom;
            tick();
        end
        bus.mem_accept = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.mem_error  = 1'b0;
        check("ready_after", req_ready, 1);
        check("rd_off", bus.mem_rd, 0);
        check("wr_off", bus.mem_wr, 0);
        check("wb_valid", wb_valid, v.e_wb);
        if (v.e_wb) begin
            check("wb_value", wb_value, v.e_val);
            check("wb_rd", wb_rd, v.rd);
        end
        check("fault_load", f_ld, v.e_fl);
        check("fault_store", f_st, v.e_fs);
        check("fault_mis", f_mis, 0);
        if (v.e_fl || v.e_fs) check("fault_addr", f_addr, v.addr);
        if (to) begin
            bus.mem_ack     = 1'b1;
            bus.mem_error   = 1'b1;
            bus.mem_data_rd = $urandom;
        end
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_error = 1'b0;
        check("pulse_end_wb", wb_valid, 0);
        check("pulse_end_fl", f_ld, 0);
        check("pulse_end_fs", f_st, 0);
        check("ready_idle", req_ready, 1);
        check("idle_rd", bus.mem_rd, 0);
        if (v.e_wb) check("wb_value_hold", wb_value, v.e_val);
        if (v.e_fl || v.e_fs) check("fault_addr_hold", f_addr, v.addr);
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input bit ld, input logic [3:0] wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input bit mis, input bit err,
                                input int acc, input int ack, input bit e_wb,
                                input logic [31:0] e_val, input bit e_fl, input bit e_fs);
        vec_t v;
        v.f3 = f3; v.ld = ld; v.wr = wr; v.rd = 5'd0; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.mis = mis; v.err = err; v.acc_dly = acc; v.ack_dly = ack;
        v.e_wb = e_wb; v.e_val = e_val; v.e_fl = e_fl; v.e_fs = e_fs;
        return v;
    endfunction

    vec_t tbl[15];
    vec_t rv;
    int   sz;
    logic [1:0] off;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        //            f3    ld wr       addr          wdata         rdata         mis err acc ack wb e_val         fl fs
        tbl[0]  = mk(3'd0, 1, 4'h0, 32'h0000_1003, 32'h0,        32'h8011_2233, 0, 0, 0,  0, 1, 32'hFFFF_FF80, 0, 0);
        tbl[1]  = mk(3'd4, 1, 4'h0, 32'h0000_1003, 32'h0,        32'h8011_2233, 0, 0, 0,  0, 1, 32'h0000_0080, 0, 0);
        tbl[2]  = mk(3'd1, 1, 4'h0, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 0, 0,  0, 1, 32'hFFFF_BEEF, 0, 0);
        tbl[3]  = mk(3'd5, 1, 4'h0, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 0, 0,  0, 1, 32'h0000_BEEF, 0, 0);
        tbl[4]  = mk(3'd2, 1, 4'h0, 32'h0000_2000, 32'h0,        32'hBEEF_1234, 0, 0, 0,  0, 1, 32'hBEEF_1234, 0, 0);
        tbl[5]  = mk(3'd2, 0, 4'hF, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0,        0, 0, 3,  0, 0, 32'h0,         0, 0);
        tbl[6]  = mk(3'd2, 1, 4'h0, 32'h0000_1002, 32'h0,        32'h0,         1, 0, 0,  0, 0, 32'h0,         0, 0);
        tbl[7]  = mk(3'd0, 0, 4'h2, 32'h0000_4001, 32'h0000_AB00, 32'h0,        0, 1, 0,  0, 0, 32'h0,         0, 1);
        tbl[8]  = mk(3'd2, 1, 4'h0, 32'h0000_5000, 32'h0,        32'h1111_2222, 0, 0, 20, 0, 0, 32'h0,         1, 0);
        tbl[9]  = mk(3'd5, 1, 4'h0, 32'h0000_6002, 32'h0,        32'h1234_5678, 0, 0, 2,  3, 1, 32'h0000_1234, 0, 0);
        tbl[10] = mk(3'd0, 1, 4'h0, 32'h0000_7001, 32'h0,        32'h0000_FF00, 0, 0, 7,  0, 1, 32'hFFFF_FFFF, 0, 0);
        tbl[11] = mk(3'd2, 1, 4'h0, 32'h0000_7100, 32'h0,        32'h3333_4444, 0, 0, 2,  6, 0, 32'h0,         1, 0);
        tbl[12] = mk(3'd2, 1, 4'h0, 32'h0000_7200, 32'h0,        32'h5555_6666, 0, 1, 1,  2, 0, 32'h0,         1, 0);
        tbl[13] = mk(3'd1, 0, 4'hC, 32'h0000_7302, 32'h5566_0000, 32'h0,        0, 0, 0,  1, 0, 32'h0,         0, 0);
        tbl[14] = mk(3'd2, 0, 4'hF, 32'h0000_7400, 32'h7777_8888, 32'h0,        0, 0, 0,  8, 0, 32'h0,         0, 1);

        rst = 1'b1;
        drive_idle();
        opcode = 32'h0; rd_idx = 5'd0; lsu_addr = 32'h0; lsu_data = 32'h0;
        bus.mem_accept = 1'b0; bus.mem_ack = 1'b0; bus.mem_error = 1'b0; bus.mem_data_rd = 32'h0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_ready", req_ready, 1);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_mem_wr", bus.mem_wr, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_value", wb_value, 0);
        check("rst_faults", {f_ld, f_st, f_mis}, 0);
        check("rst_fault_addr", f_addr, 0);

        for (int i = 0; i < 15; i++) begin
            cur_op = i;
            rv = tbl[i];
            rv.rd = 5'((i * 7 + 3) % 32);
            run_op(rv);
        end

        // Valid without read or write strobes is not an op.
        cur_op = 50;
        present(3'd2, 1'b0, 4'h0, 5'd1, 32'h0000_0900, 32'h0, 1'b0);
        tick();
        drive_idle();
        check("noop_ready", req_ready, 1);
        check("noop_rd", bus.mem_rd, 0);
        check("noop_wr", bus.mem_wr, 0);
        tick();

        // Back-to-back: second op captured in the cycle the first writes back.
        cur_op = 51;
        present(3'd2, 1'b1, 4'h0, 5'd9, 32'h0000_0100, 32'h0, 1'b0);
        tick();
        drive_idle();
        check("b2b_rd1", bus.mem_rd, 1);
        check("b2b_addr1", bus.mem_addr, 32'h0000_0100);
        bus.mem_accept = 1'b1; bus.mem_ack = 1'b1; bus.mem_data_rd = 32'h1111_1111;
        tick();
        bus.mem_accept = 1'b0; bus.mem_ack = 1'b0;
        check("b2b_wb1", wb_valid, 1);
        check("b2b_val1", wb_value, 32'h1111_1111);
        check("b2b_ready", req_ready, 1);
        present(3'd4, 1'b1, 4'h0, 5'd10, 32'h0000_0103, 32'h0, 1'b0);
        tick();
        drive_idle();
        check("b2b_wb_gap", wb_valid, 0);
        check("b2b_rd2", bus.mem_rd, 1);
        check("b2b_busy2", req_ready, 0);
        bus.mem_accept = 1'b1; bus.mem_ack = 1'b1; bus.mem_data_rd = 32'hAB00_0000;
        tick();
        bus.mem_accept = 1'b0; bus.mem_ack = 1'b0;
        check("b2b_wb2", wb_valid, 1);
        check("b2b_val2", wb_value, 32'h0000_00AB);
        check("b2b_rdidx2", wb_rd, 10);
        tick();

        // Reset while waiting for the response; a later ack must be ignored.
        cur_op = 52;
        present(3'd2, 1'b1, 4'h0, 5'd4, 32'h0000_0800, 32'h0, 1'b0);
        tick();
        drive_idle();
        bus.mem_accept = 1'b1;
        tick();
        bus.mem_accept = 1'b0;
        check("rresp_busy", req_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rresp_ready", req_ready, 1);
        check("rresp_rd", bus.mem_rd, 0);
        check("rresp_wb", wb_valid, 0);
        check("rresp_faults", {f_ld, f_st, f_mis}, 0);
        bus.mem_ack = 1'b1; bus.mem_data_rd = 32'hCAFE_F00D;
        tick();
        bus.mem_ack = 1'b0;
        check("rresp_late_wb", wb_valid, 0);
        check("rresp_late_ready", req_ready, 1);
        check("rresp_late_faults", {f_ld, f_st, f_mis}, 0);

        for (int n = 0; n < 200; n++) begin
            cur_op = 100 + n;
            rv.ld   = 1'($urandom_range(0, 1));
            sz      = $urandom_range(0, 2);
            rv.addr = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (sz == 1) rv.addr[0] = 1'b0;
                if (sz == 2) rv.addr[1:0] = 2'b00;
            end
            off    = rv.addr[1:0];
            rv.mis = (sz == 1 && off[0]) || (sz == 2 && off != 2'b00);
            if (rv.ld) begin
                rv.f3 = 3'(sz);
                if (sz != 2 && $urandom_range(0, 1) == 1) rv.f3[2] = 1'b1;
                rv.wr = 4'h0;
            end else begin
                rv.f3 = 3'(sz);
                rv.wr = (sz == 0) ? (4'b0001 << off) : (sz == 1) ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            end
            rv.rd      = 5'($urandom);
            rv.wdata   = $urandom;
            rv.rdata   = $urandom;
            rv.err     = ($urandom_range(0, 5) == 0);
            rv.acc_dly = $urandom_range(0, 4);
            rv.ack_dly = $urandom_range(0, 5);
            rv = predict(rv);
            run_op(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
